eff_i2s_tx: RTL and testbench
=============================

Name: eff_i2s_tx

Overview:
- Sink end of the effect-chain sample stream: accepts data_o/vld_o-style samples from the last effect stage and serialises them to an external I2S DAC.
- Buffers samples in a 2-entry FIFO and generates bclk/lrclk internally from clk.
- Sends each mono sample on both left and right slots.
- Flags overflow (source too fast) and underrun (source too slow, last sample repeated).

Parameters:
- DATA_WIDTH, 8, sample width in bits; samples are raw bits, sent MSB first.
- SLOT_WIDTH, 16, bclk periods per channel slot; must be >= DATA_WIDTH.
- CLK_DIV, 2, clk cycles per bclk half-period; must be >= 1.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- data_i  input  DATA_WIDTH  sample from effect chain.
- vld_i  input  1  data_i valid; one-cycle strobe; no backpressure.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  I2S word select (0 = left, 1 = right).
- sdata  output  1  I2S serial data.
- ovf  output  1  sticky overflow flag.
- udf  output  1  one-cycle underrun pulse.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - Outputs: bclk=0, lrclk=0, sdata=0, ovf=0, udf=0.
  - Internal: FIFO empty, held sample=0, div_cnt=0, bit_cnt=2*SLOT_WIDTH-1.
  - Reset asserted mid-frame aborts immediately, discards FIFO contents and returns everything to these values.
- Bit clock:
  - div_cnt counts 0..CLK_DIV-1 on every clk and wraps.
  - bclk toggles on the cycle div_cnt==CLK_DIV-1.
  - bclk period = 2*CLK_DIV clk cycles.
  - A "fall event" is the clk cycle in which bclk toggles 1->0; all serial state updates only on fall events.
- Frame counter: on each fall event bit_cnt <= (bit_cnt+1) mod 2*SLOT_WIDTH. The first fall event after reset gives k=0 (k = updated bit_cnt).
- Outputs on a fall event (registered):
  - lrclk <= (k >= SLOT_WIDTH).
  - sdata <= bit p of the slot word, where p = (k-1) mod SLOT_WIDTH and p=0 is the MSB.
  - Slot word = held sample left-justified in SLOT_WIDTH bits, zero-padded in the LSBs.
  - This gives the standard I2S one-bclk delay after each lrclk change.
- Sample load, on the fall event with k=1:
  - FIFO not empty: pop the head into held; sdata in that same event takes the MSB of the popped value.
  - FIFO empty: keep held unchanged (previous sample repeated) and pulse udf high for exactly one clk cycle.
  - Right slot (k=SLOT_WIDTH+1..) re-sends the same held sample.
- FIFO, depth 2:
  - vld_i with the FIFO not full: push data_i.
  - vld_i with the FIFO full: drop data_i and set ovf=1.
  - ovf stays 1 until reset.
  - Push and pop in the same cycle with the FIFO full: pop first, push accepted, no ovf.
  - Push and pop in the same cycle with the FIFO empty: the pop finds it empty (udf pulses), the push is stored.
  - Occupancy is never observable beyond 2.
- Latency: a sample pushed into an empty FIFO is driven (MSB) at the next k=1 fall event; worst case one frame = 2*SLOT_WIDTH*2*CLK_DIV clk cycles.
- bclk, lrclk and sdata are all registered; no combinational path from inputs to outputs.

Test Plan:
(DATA_WIDTH=8, SLOT_WIDTH=16, CLK_DIV=2; bclk period 4 clk, frame 128 clk.)
1. Reset, then idle → bclk free-runs with period 4, lrclk toggles every 64 clk, sdata=0 throughout; udf pulses once per frame (every 128 clk).
2. Push 0xA5 before the first k=1 event → left slot after lrclk falls is 0,1,0,1,0,0,1,0,1 then 8 zeros (delay bit, then 10100101, then padding); right slot identical; no udf that frame.
3. Push 0x80 then 0x01, one per frame → frame 1 sends 0x80 on both slots, frame 2 sends 0x01 on both; ovf=0, udf=0.
4. Push 0x11, 0x22, 0x33 within one frame, before any load → ovf=1 and stays 1; frames send 0x11 then 0x22; 0x33 never appears.
5. Push 0x7F once, then no input → every later frame repeats 0x7F; udf pulses one clk cycle at each k=1 event after the first.
6. Deassert rst_n mid right slot with 2 samples queued → all outputs 0 immediately (asynchronous); after release, the first frame sends 0x00 with udf pulse and ovf=0.

Source files
------------

// File: rtl/eff_i2s_tx.sv
// I2S transmitter at the end of the effect chain: a 2-entry sample FIFO feeding a
// mono-to-stereo serialiser, with bclk/lrclk derived from clk by a free-running divider.
module eff_i2s_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SLOT_WIDTH = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int BIT_W = $clog2(FRAME);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] SLOT_END = BIT_W'(SLOT_WIDTH - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  bclk_q, bclk_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic [DATA_WIDTH-1:0] mem_q [0:1];
  logic [DATA_WIDTH-1:0] mem_d [0:1];
  logic [1:0]            cnt_q, cnt_d;

  logic                  tick, fall, load, pop, push;
  logic [BIT_W-1:0]      k, pos;

  assign tick = (div_cnt_q == DIV_LAST);
  assign fall = tick && bclk_q;
  assign k    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_ONE;
  assign load = fall && (k == BIT_ONE);
  assign pop  = load && (cnt_q != 2'd0);
  // A full FIFO still accepts a push when the same cycle pops.
  assign push = vld_i && ((cnt_q != 2'd2) || pop);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_ONE;
    bclk_d    = tick ? ~bclk_q : bclk_q;
    bit_cnt_d = fall ? k : bit_cnt_q;
    lrclk_d   = fall ? (k >= SLOT) : lrclk_q;
    held_d    = pop ? mem_q[0] : held_q;
    udf_d     = load && (cnt_q == 2'd0);
  end

  // Bit position within the slot word; k=0 carries the last bit of the right slot.
  always_comb begin
    pos = '0;
    if (k == '0)
      pos = SLOT_END;
    else if (k <= SLOT)
      pos = k - BIT_ONE;
    else
      pos = k - BIT_ONE - SLOT;
  end

  always_comb begin
    sdata_d = sdata_q;
    if (fall) begin
      sdata_d = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++)
        if (pos == BIT_W'(i)) sdata_d = held_d[DATA_WIDTH-1-i];
    end
  end

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | (vld_i && !push);
    if (pop) begin
      mem_d[0] = mem_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) mem_d[0] = data_i;
      else               mem_d[1] = data_i;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= BIT_LAST;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      held_q    <= '0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      cnt_q     <= 2'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      held_q    <= held_d;
      mem_q     <= mem_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;
  assign sdata = sdata_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_eff_i2s_tx.sv
// Bench for eff_i2s_tx: a frame-level reference model queues the expected sample per frame,
// and an I2S receiver decodes the serial output and compares each slot word.
module tb_eff_i2s_tx;

  localparam int DW        = 8;
  localparam int SW        = 16;
  localparam int CD        = 2;
  localparam int FRAME_CLK = 4 * SW * CD;
  localparam int LOAD_PH   = 4 * CD;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_i;
  logic          vld_i;
  logic          bclk, lrclk, sdata, ovf, udf;

  int errors = 0;
  int checks = 0;
  int words_rx = 0;

  eff_i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .vld_i(vld_i),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clock edge n after reset; samples load at every frame's load edge.
  int            cyc;
  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] m_held;
  logic [DW-1:0] exp_q[$];
  logic          ovf_exp, udf_exp, bclk_exp;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      m_fifo.delete();
      exp_q.delete();
      m_held = '0;
      ovf_exp = 1'b0;
      udf_exp = 1'b0;
      bclk_exp = 1'b0;
    end else begin
      cyc++;
      bclk_exp = ((cyc / CD) % 2) == 1;
      udf_exp = 1'b0;
      if (cyc % FRAME_CLK == LOAD_PH) begin
        if (m_fifo.size() > 0) m_held = m_fifo.pop_front();
        else udf_exp = 1'b1;
        exp_q.push_back(m_held);
      end
      if (vld_i) begin
        if (m_fifo.size() < 2) m_fifo.push_back(data_i);
        else ovf_exp = 1'b1;
      end
    end
  end

  // Monitor: per-cycle flag/clock checks plus an I2S receiver sampling on bclk rising.
  logic [SW-1:0] rx_sr;
  int            rx_nb;
  logic          rx_lr, rx_bclk;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_sr = '0;
      rx_nb = 0;
      rx_lr = 1'b0;
      rx_bclk = 1'b0;
    end else begin
      chk("bclk", 32'(bclk), 32'(bclk_exp));
      chk("udf", 32'(udf), 32'(udf_exp));
      chk("ovf", 32'(ovf), 32'(ovf_exp));
      if (bclk && !rx_bclk) begin
        rx_sr = {rx_sr[SW-2:0], sdata};
        rx_nb++;
        if (lrclk != rx_lr) begin
          if (rx_nb >= SW) begin
            words_rx++;
            if (exp_q.size() == 0) begin
              chk("word_unexpected", 32'(rx_sr), 32'hFFFF_FFFF);
            end else begin
              logic [SW-1:0] w;
              w = SW'(exp_q[0]) << (SW - DW);
              chk(rx_lr ? "right_word" : "left_word", 32'(rx_sr), 32'(w));
              if (rx_lr) void'(exp_q.pop_front());
            end
          end
          rx_nb = 0;
          rx_lr = lrclk;
        end
      end
      rx_bclk = bclk;
    end
  end

  // Returns at the negedge just before clock edge n with n mod FRAME_CLK == ph.
  task automatic wait_phase(input int ph);
    do @(negedge clk); while (((cyc + 1) % FRAME_CLK) != ph);
  endtask

  task automatic drive_at(input int ph, input logic [DW-1:0] d);
    wait_phase(ph);
    vld_i = 1'b1;
    data_i = d;
    @(negedge clk);
    vld_i = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    repeat (n * FRAME_CLK) @(negedge clk);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    vld_i = 1'b0;
    data_i = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Push before the first load, then idle: repeated sample with udf each frame.
    drive_at(3, 8'hA5);
    idle_frames(2);

    drive_at(40, 8'h80);
    drive_at(40, 8'h01);
    drive_at(40, 8'h7F);
    idle_frames(3);

    // Full FIFO with push coinciding with pop: no overflow.
    wait_phase(50);
    vld_i = 1'b1; data_i = 8'h3C;
    @(negedge clk); data_i = 8'hC3;
    @(negedge clk); vld_i = 1'b0;
    drive_at(LOAD_PH, 8'h5A);
    idle_frames(3);

    // Empty FIFO with push coinciding with pop: underrun, push kept for next frame.
    drive_at(LOAD_PH, 8'h96);
    idle_frames(2);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      vld_i = 1'b1;
      data_i = DW'($urandom);
      @(negedge clk);
      vld_i = 1'b0;
    end
    idle_frames(3);

    // Three back-to-back pushes: the third overflows.
    wait_phase(30);
    vld_i = 1'b1; data_i = 8'h11;
    @(negedge clk); data_i = 8'h22;
    @(negedge clk); data_i = 8'h33;
    @(negedge clk); vld_i = 1'b0;
    idle_frames(3);

    // Asynchronous reset in the right slot with two samples queued.
    wait_phase(20);
    vld_i = 1'b1; data_i = 8'h44;
    @(negedge clk); data_i = 8'h55;
    @(negedge clk); vld_i = 1'b0;
    wait_phase(80);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_lrclk", 32'(lrclk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle_frames(3);

    chk("words_rx_min", 32'(words_rx >= 40), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
